// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared game-state, collision and direction codes for the snake game blocks
// Ports: none (package). Provides game_state_e, collision_e, direction_e and pick_verdict().
package snake_pkg;

    typedef enum logic [1:0] {
        GS_IDLE      = 2'b00,
        GS_PLAY      = 2'b01,
        GS_GAME_OVER = 2'b11
    } game_state_e;

    typedef enum logic [1:0] {
        COL_NONE  = 2'b00,
        COL_WALL  = 2'b01,
        COL_APPLE = 2'b10,
        COL_SELF  = 2'b11
    } collision_e;

    typedef enum logic [2:0] {
        DIR_IDLE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_DOWN  = 3'd2,
        DIR_LEFT  = 3'd3,
        DIR_RIGHT = 3'd4
    } direction_e;

    // Fatal hits outrank the apple so a head that reaches the apple and a
    // wall in the same frame still ends the game.
    function automatic collision_e pick_verdict(input logic wall, input logic self_hit,
                                                input logic apple);
        if (wall)
            return COL_WALL;
        else if (self_hit)
            return COL_SELF;
        else if (apple)
            return COL_APPLE;
        else
            return COL_NONE;
    endfunction

endpackage

// File: rtl/snake_collision_ctrl_if.sv
// rtl/snake_collision_ctrl_if.sv - scan-side inputs and game-rule outputs of the collision controller
// master: drawing/scan side (drives x_pos, y_pos, video_on, frame_start, pixel flags, direction;
//         receives game_state, collision, update, apple_respawn, score)
// slave:  snake_collision_ctrl (the opposite directions)
interface snake_collision_ctrl_if #(
    parameter int BIT = 10
);
    import snake_pkg::*;

    logic [BIT-1:0] x_pos;
    logic [BIT-1:0] y_pos;
    logic           video_on;
    logic           frame_start;
    logic           head_active;
    logic           body_active;
    logic           apple_active;
    logic [2:0]     direction;
    game_state_e    game_state;
    collision_e     collision;
    logic           update;
    logic           apple_respawn;
    logic [7:0]     score;

    modport master (
        output x_pos, y_pos, video_on, frame_start,
        output head_active, body_active, apple_active, direction,
        input  game_state, collision, update, apple_respawn, score
    );

    modport slave (
        input  x_pos, y_pos, video_on, frame_start,
        input  head_active, body_active, apple_active, direction,
        output game_state, collision, update, apple_respawn, score
    );

endinterface

// File: rtl/collision_accum.sv
// rtl/collision_accum.sv - per-frame sticky wall/self/apple hit detection
// Inputs:  clk, reset (sync, active-high), x_pos/y_pos/video_on (scan position),
//          frame_start, head_active/body_active/apple_active (one clock behind x_pos/y_pos)
// Outputs: hit_wall, hit_self, hit_apple (accumulated over the current frame)
module collision_accum
    import snake_pkg::*;
#(
    parameter int BIT      = 10,
    parameter int SIZE     = 10,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [BIT-1:0] x_pos,
    input  logic [BIT-1:0] y_pos,
    input  logic           video_on,
    input  logic           frame_start,
    input  logic           head_active,
    input  logic           body_active,
    input  logic           apple_active,
    output logic           hit_wall,
    output logic           hit_self,
    output logic           hit_apple
);

    // The pixel flags describe the previous scan position, so compare them
    // against a one-stage delayed copy of the position.
    logic [BIT-1:0] x_d;
    logic [BIT-1:0] y_d;
    logic           video_on_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_d        <= '0;
            y_d        <= '0;
            video_on_d <= 1'b0;
        end else begin
            x_d        <= x_pos;
            y_d        <= y_pos;
            video_on_d <= video_on;
        end
    end

    logic in_border;
    logic sample_wall;
    logic sample_self;
    logic sample_apple;

    assign in_border = (x_d < BIT'(SIZE)) || (x_d >= BIT'(H_ACTIVE - SIZE)) ||
                       (y_d < BIT'(SIZE)) || (y_d >= BIT'(V_ACTIVE - SIZE));

    assign sample_wall  = video_on_d && head_active && in_border;
    assign sample_self  = video_on_d && head_active && body_active;
    assign sample_apple = video_on_d && head_active && apple_active;

    // frame_start restarts the frame; the sample of that very cycle already
    // belongs to the new frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_wall  <= 1'b0;
            hit_self  <= 1'b0;
            hit_apple <= 1'b0;
        end else if (frame_start) begin
            hit_wall  <= sample_wall;
            hit_self  <= sample_self;
            hit_apple <= sample_apple;
        end else begin
            hit_wall  <= hit_wall  | sample_wall;
            hit_self  <= hit_self  | sample_self;
            hit_apple <= hit_apple | sample_apple;
        end
    end

endmodule

// File: rtl/snake_collision_ctrl.sv
// rtl/snake_collision_ctrl.sv - snake game rules: collision verdict, IDLE/PLAY/GAME_OVER FSM, move tick, score
// Ports: clk, reset (sync, active-high), bus (snake_collision_ctrl_if.slave: scan inputs,
//        pixel flags, direction in; game_state, collision, update, apple_respawn, score out)
// Option: SNAKE_SPEEDUP_EN - move period shrinks with score (MOVE_FRAMES - score/2, min 2)
module snake_collision_ctrl
    import snake_pkg::*;
#(
    parameter int BIT         = 10,
    parameter int SIZE        = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int MOVE_FRAMES = 8,
    parameter int OVER_FRAMES = 120,
    parameter int MAX_SCORE   = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    snake_collision_ctrl_if.slave bus
);

    localparam int FW = $clog2(OVER_FRAMES + 1);

    logic hit_wall;
    logic hit_self;
    logic hit_apple;

    collision_accum #(
        .BIT      (BIT),
        .SIZE     (SIZE),
        .H_ACTIVE (H_ACTIVE),
        .V_ACTIVE (V_ACTIVE)
    ) u_accum (
        .clk          (clk),
        .reset        (reset),
        .x_pos        (bus.x_pos),
        .y_pos        (bus.y_pos),
        .video_on     (bus.video_on),
        .frame_start  (bus.frame_start),
        .head_active  (bus.head_active),
        .body_active  (bus.body_active),
        .apple_active (bus.apple_active),
        .hit_wall     (hit_wall),
        .hit_self     (hit_self),
        .hit_apple    (hit_apple)
    );

    game_state_e   state_q, state_n;
    collision_e    collision_q, collision_n;
    collision_e    verdict;
    logic [7:0]    score_q, score_n;
    logic [7:0]    move_cnt_q, move_cnt_n;
    logic [7:0]    period_q, period_n;
    logic [7:0]    period_calc;
    logic [FW-1:0] frame_cnt_q, frame_cnt_n;
    logic          tick_q, tick_n;
    logic          update_q, update_n;
    logic          respawn_q, respawn_n;

    // Sampled on the frame_start cycle the accumulators still hold the
    // finished frame's bits.
    assign verdict = pick_verdict(hit_wall, hit_self, hit_apple);

`ifdef SNAKE_SPEEDUP_EN
    logic [7:0] half_score;
    assign half_score  = score_q >> 1;
    assign period_calc = (int'(half_score) + 2 >= MOVE_FRAMES) ? 8'd2
                                                               : 8'(MOVE_FRAMES - int'(half_score));
`else
    assign period_calc = 8'(MOVE_FRAMES);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= GS_IDLE;
            collision_q <= COL_NONE;
            score_q     <= '0;
            move_cnt_q  <= '0;
            period_q    <= 8'(MOVE_FRAMES);
            frame_cnt_q <= '0;
            tick_q      <= 1'b0;
            update_q    <= 1'b0;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_n;
            collision_q <= collision_n;
            score_q     <= score_n;
            move_cnt_q  <= move_cnt_n;
            period_q    <= period_n;
            frame_cnt_q <= frame_cnt_n;
            tick_q      <= tick_n;
            update_q    <= update_n;
            respawn_q   <= respawn_n;
        end
    end

    always_comb begin
        state_n     = state_q;
        collision_n = collision_q;
        score_n     = score_q;
        move_cnt_n  = move_cnt_q;
        period_n    = period_q;
        frame_cnt_n = frame_cnt_q;
        tick_n      = 1'b0;
        // The tick is delayed one more stage so the drawing block sees the
        // new game_state before it moves the snake.
        update_n    = tick_q;
        respawn_n   = 1'b0;

        case (state_q)
            GS_IDLE: begin
                if (bus.frame_start)
                    collision_n = COL_NONE;
                // Start is checked every clock, not just at frame boundaries.
                if (bus.direction != 3'(DIR_IDLE)) begin
                    state_n    = GS_PLAY;
                    move_cnt_n = '0;
                    period_n   = period_calc;
                end
            end

            GS_PLAY: begin
                if (bus.frame_start) begin
                    collision_n = verdict;
                    if (verdict == COL_WALL || verdict == COL_SELF) begin
                        state_n     = GS_GAME_OVER;
                        frame_cnt_n = '0;
                    end else begin
                        if (verdict == COL_APPLE) begin
                            respawn_n = 1'b1;
                            if (score_q < 8'(MAX_SCORE))
                                score_n = score_q + 8'd1;
                        end
                        if (move_cnt_q >= period_q - 8'd1) begin
                            move_cnt_n = '0;
                            tick_n     = 1'b1;
                            period_n   = period_calc;
                        end else begin
                            move_cnt_n = move_cnt_q + 8'd1;
                        end
                    end
                end
            end

            GS_GAME_OVER: begin
                if (bus.frame_start) begin
                    collision_n = COL_NONE;
                    if (frame_cnt_q == FW'(OVER_FRAMES - 1)) begin
                        state_n     = GS_IDLE;
                        score_n     = '0;
                        frame_cnt_n = '0;
                    end else begin
                        frame_cnt_n = frame_cnt_q + FW'(1);
                    end
                end
            end

            default: state_n = GS_IDLE;
        endcase
    end

    assign bus.game_state    = state_q;
    assign bus.collision     = collision_q;
    assign bus.update        = update_q;
    assign bus.apple_respawn = respawn_q;
    assign bus.score         = score_q;

endmodule
